ret_pred_ctrl: RTL and testbench

Return-address prediction controller between the decode stage and the return stack. It classifies each decoded JAL/JALR as call, return or coroutine swap and drives the stack's push/pop strobes. On a return it forwards the stack top to fetch as the predicted target. It queues each prediction until execute resolves the real target, then reports mispredictions.

---
 rtl/ret_pred_ctrl_pkg.sv | 50 +++++
 rtl/ret_pred_ctrl_if.sv | 37 +++
 rtl/ret_pend_fifo.sv | 59 +++++
 rtl/ret_pred_ctrl.sv | 142 ++++++++++++++
 tb/tb_ret_pred_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ret_pred_ctrl_pkg.sv
// Shared types and constants for the return-address prediction controller.
package ret_pred_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] LINK_X1  = 5'd1;
  localparam logic [4:0] LINK_X5  = 5'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CORO = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_PUSH,
    CLS_POP,
    CLS_CORO
  } cls_e;

  typedef struct packed {
    logic                  pred;
    logic [ADDR_WIDTH-1:0] target;
  } pend_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_X1) || (r == LINK_X5);
  endfunction

  // Return-stack hint decoding for JAL/JALR based on link-register usage.
  function automatic cls_e classify(input logic [6:0] opc, input logic [4:0] rd,
                                    input logic [4:0] rs1);
    cls_e c;
    c = CLS_NONE;
    if (opc == OPC_JAL) begin
      if (is_link(rd)) c = CLS_PUSH;
    end else if (opc == OPC_JALR) begin
      case ({is_link(rd), is_link(rs1)})
        2'b10:   c = CLS_PUSH;
        2'b01:   c = CLS_POP;
        2'b11:   c = (rd == rs1) ? CLS_PUSH : CLS_CORO;
        default: c = CLS_NONE;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ret_pred_ctrl_if.sv
// Decode / return-stack / execute signal bundle for ret_pred_ctrl.
interface ret_pred_ctrl_if import ret_pred_ctrl_pkg::*; #(
  parameter int CNT_WIDTH = 16
);

  logic                  dec_valid;
  logic [31:0]           instr_dec;
  logic [ADDR_WIDTH-1:0] pc_dec;
  logic                  stack_empty;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  ret_stack_wen;
  logic                  ret_stack_ren;
  logic                  dec_stall;
  logic                  pred_valid;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  ex_ret_valid;
  logic [ADDR_WIDTH-1:0] ex_ret_target;
  logic                  flush;
  logic                  mispred;
  logic [ADDR_WIDTH-1:0] mispred_target;
  logic [CNT_WIDTH-1:0]  mispred_cnt;

  modport slave (
    input  dec_valid, instr_dec, pc_dec, stack_empty, ret_addr,
           ex_ret_valid, ex_ret_target, flush,
    output ret_stack_wen, ret_stack_ren, dec_stall, pred_valid, pred_target,
           mispred, mispred_target, mispred_cnt
  );

  modport master (
    output dec_valid, instr_dec, pc_dec, stack_empty, ret_addr,
           ex_ret_valid, ex_ret_target, flush,
    input  ret_stack_wen, ret_stack_ren, dec_stall, pred_valid, pred_target,
           mispred, mispred_target, mispred_cnt
  );

endinterface

// File: rtl/ret_pend_fifo.sv
// Pending-prediction FIFO: one entry per unresolved return, clear beats enq/deq.
module ret_pend_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             cpu_clk,
  input  logic             cpu_rstn,
  input  logic             enq_i,
  input  logic [WIDTH-1:0] enq_data_i,
  input  logic             deq_i,
  input  logic             clr_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [PW:0]      count_q;
  logic             do_enq, do_deq;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_enq = enq_i && !clr_i && !full_o;
  assign do_deq = deq_i && !clr_i && !empty_o;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_deq) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count_q is non-zero.
  always_ff @(posedge cpu_clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= enq_data_i;
  end

endmodule

// File: rtl/ret_pred_ctrl.sv
// Return-address prediction controller: classifies JAL/JALR, drives return-stack
// strobes, predicts return targets and reports mispredictions from execute.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | classify decode; push / pop / start coroutine
//   ST_CORO | coroutine second half: push the held pc_dec, then back to IDLE
module ret_pred_ctrl import ret_pred_ctrl_pkg::*; #(
  parameter int pend_depth = 4,
  parameter int cnt_width  = 16
) (
  input logic            cpu_clk,
  input logic            cpu_rstn,
  ret_pred_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  cls_e                  cls;
  logic                  ret_cls;
  logic                  fifo_full, fifo_empty;
  logic                  enq, deq, clr;
  pend_t                 enq_data, head;
  logic                  wen, ren, pv, stall;
  logic [ADDR_WIDTH-1:0] pt;
  logic                  mispred_d, mispred_q;
  logic [ADDR_WIDTH-1:0] mtgt_d, mtgt_q;
  logic [cnt_width-1:0]  cnt_d, cnt_q;
  logic                  unused_instr;

  assign cls = classify(bus.instr_dec[6:0], bus.instr_dec[11:7], bus.instr_dec[19:15]);
  assign unused_instr = ^{bus.instr_dec[31:20], bus.instr_dec[14:12]};
  assign ret_cls = bus.dec_valid && (state_q == ST_IDLE) &&
                   ((cls == CLS_POP) || (cls == CLS_CORO));

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enq && (cls == CLS_CORO)) state_d = ST_CORO;
      ST_CORO: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A coroutine stalls decode in its first cycle so pc_dec is still held
  // when the push happens in ST_CORO.
  always_comb begin
    wen      = 1'b0;
    ren      = 1'b0;
    pv       = 1'b0;
    pt       = '0;
    stall    = 1'b0;
    enq      = 1'b0;
    enq_data = '0;
    if (bus.dec_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ret_cls && fifo_full) begin
            stall = 1'b1;
          end else begin
            if (cls == CLS_CORO) stall = 1'b1;
            if (!bus.flush) begin
              case (cls)
                CLS_PUSH: wen = 1'b1;
                CLS_POP, CLS_CORO: begin
                  enq           = 1'b1;
                  enq_data.pred = !bus.stack_empty;
                  if (!bus.stack_empty) begin
                    ren             = 1'b1;
                    pv              = 1'b1;
                    pt              = bus.ret_addr;
                    enq_data.target = bus.ret_addr;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_CORO: wen = !bus.flush;
        default: ;
      endcase
    end
  end

  assign bus.ret_stack_wen = wen;
  assign bus.ret_stack_ren = ren;
  assign bus.pred_valid    = pv;
  assign bus.pred_target   = pt;
  assign bus.dec_stall     = stall;

  // A mispredict flushes younger predictions; the FIFO lets clr win over enq.
  assign mispred_d = bus.ex_ret_valid && !bus.flush &&
                     (fifo_empty || !head.pred || (head.target != bus.ex_ret_target));
  assign deq = bus.ex_ret_valid && !bus.flush && !fifo_empty;
  assign clr = bus.flush || mispred_d;

  ret_pend_fifo #(
    .DEPTH (pend_depth),
    .WIDTH ($bits(pend_t))
  ) u_pend_fifo (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .enq_i      (enq),
    .enq_data_i (enq_data),
    .deq_i      (deq),
    .clr_i      (clr),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  always_comb begin
    mtgt_d = mtgt_q;
    cnt_d  = cnt_q;
    if (mispred_d) begin
      mtgt_d = bus.ex_ret_target;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      mispred_q <= 1'b0;
      mtgt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      mispred_q <= mispred_d;
      mtgt_q    <= mtgt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.mispred        = mispred_q;
  assign bus.mispred_target = mtgt_q;
  assign bus.mispred_cnt    = cnt_q;

endmodule

// File: tb/tb_ret_pred_ctrl.sv
// Scoreboard bench for ret_pred_ctrl: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ret_pred_ctrl;
  import ret_pred_ctrl_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic cpu_clk  = 1'b0;
  logic cpu_rstn = 1'b0;

  ret_pred_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  ret_pred_ctrl #(.pend_depth(DEPTH), .cnt_width(CW)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic wen, ren, pv, stall; logic [31:0] pt; } comb_exp_t;
  typedef struct { int cyc; logic [31:0] tgt; } mis_exp_t;
  typedef struct { logic pred; logic [31:0] tgt; } pend_m_t;

  comb_exp_t   comb_q[$];
  mis_exp_t    mis_q[$];
  pend_m_t     pend[$];
  logic [31:0] stk[$];
  bit          coro_m;
  bit          check_en;
  logic [31:0] exp_mt;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations stamped with the current cycle and compares.
  comb_exp_t me;
  logic      exp_mis;
  always @(negedge cpu_clk) begin
    if (cpu_rstn && check_en) begin
      exp_mis = 1'b0;
      if (mis_q.size() != 0 && mis_q[0].cyc == cyc) begin
        exp_mis = 1'b1;
        exp_mt  = mis_q[0].tgt;
        if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        void'(mis_q.pop_front());
      end
      chk("mispred", bus.mispred, exp_mis);
      chk("mispred_target", bus.mispred_target, exp_mt);
      chk("mispred_cnt", bus.mispred_cnt, exp_cnt);
      if (comb_q.size() != 0 && comb_q[0].cyc == cyc) begin
        me = comb_q.pop_front();
        chk("wen", bus.ret_stack_wen, me.wen);
        chk("ren", bus.ret_stack_ren, me.ren);
        chk("pred_valid", bus.pred_valid, me.pv);
        chk("pred_target", bus.pred_target, me.pt);
        chk("dec_stall", bus.dec_stall, me.stall);
      end
    end
  end

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, opc};
  endfunction

  // 0 none, 1 push, 2 pop, 3 coroutine -- straight from the hint table
  function automatic int ref_kind(input logic [31:0] instr);
    logic [6:0] opc;
    logic rdl, rsl;
    opc = instr[6:0];
    rdl = (instr[11:7] == 5'd1) || (instr[11:7] == 5'd5);
    rsl = (instr[19:15] == 5'd1) || (instr[19:15] == 5'd5);
    if (opc == 7'b1101111) return rdl ? 1 : 0;
    if (opc == 7'b1100111) begin
      if (rdl && !rsl) return 1;
      if (!rdl && rsl) return 2;
      if (rdl && rsl) return (instr[11:7] == instr[19:15]) ? 1 : 3;
    end
    return 0;
  endfunction

  task automatic drive(input logic dv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic exv, input logic [31:0] ext, input logic fl,
                       output logic stalled);
    comb_exp_t e;
    pend_m_t   ne, h;
    int        kind;
    bit        enq, mis, coro_next;
    bus.dec_valid     = dv;
    bus.instr_dec     = instr;
    bus.pc_dec        = pc;
    bus.stack_empty   = (stk.size() == 0);
    bus.ret_addr      = (stk.size() != 0) ? stk[$] : $urandom();
    bus.ex_ret_valid  = exv;
    bus.ex_ret_target = ext;
    bus.flush         = fl;
    kind = ref_kind(instr);
    e = '{cyc: cyc, wen: 1'b0, ren: 1'b0, pv: 1'b0, stall: 1'b0, pt: 32'h0};
    ne = '{pred: 1'b0, tgt: 32'h0};
    enq = 0;
    coro_next = 0;
    if (dv) begin
      if (coro_m) e.wen = !fl;
      else if (kind >= 2 && pend.size() == DEPTH) e.stall = 1'b1;
      else begin
        if (kind == 3) e.stall = 1'b1;
        if (!fl && kind == 1) e.wen = 1'b1;
        if (!fl && kind >= 2) begin
          enq       = 1;
          ne.pred   = !bus.stack_empty;
          ne.tgt    = bus.stack_empty ? 32'h0 : bus.ret_addr;
          e.ren     = !bus.stack_empty;
          e.pv      = !bus.stack_empty;
          e.pt      = ne.tgt;
          coro_next = (kind == 3);
        end
      end
    end
    mis = 0;
    if (exv && !fl) begin
      if (pend.size() == 0) mis = 1;
      else begin
        h   = pend.pop_front();
        mis = !h.pred || (h.tgt != ext);
      end
    end
    if (fl || mis) begin
      pend.delete();
      enq = 0;
    end
    if (enq) pend.push_back(ne);
    if (mis) mis_q.push_back('{cyc: cyc + 1, tgt: ext});
    if (dv) comb_q.push_back(e);
    if (e.wen) stk.push_back(pc + 32'd4);
    if (e.ren) void'(stk.pop_back());
    coro_m  = coro_next;
    stalled = e.stall;
    #2;
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic step(input logic dv, input logic [31:0] instr, input logic [31:0] pc,
                      input logic exv, input logic [31:0] ext, input logic fl);
    logic s;
    drive(dv, instr, pc, exv, ext, fl, s);
    tick();
  endtask

  task automatic do_reset();
    logic s;
    check_en = 0;
    cpu_rstn = 1'b0;
    comb_q.delete();
    mis_q.delete();
    pend.delete();
    coro_m  = 0;
    exp_mt  = '0;
    exp_cnt = '0;
    drive(0, 32'h0, 32'h0, 0, 32'h0, 0, s);
    repeat (2) tick();
    chk("rst mispred", bus.mispred, 0);
    chk("rst mispred_target", bus.mispred_target, 0);
    chk("rst mispred_cnt", bus.mispred_cnt, 0);
    chk("rst wen", bus.ret_stack_wen, 0);
    chk("rst ren", bus.ret_stack_ren, 0);
    chk("rst dec_stall", bus.dec_stall, 0);
    chk("rst pred_valid", bus.pred_valid, 0);
    cpu_rstn = 1'b1;
    check_en = 1;
    tick();
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      default: return 5'd2;
    endcase
  endfunction

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  initial begin : stim
    logic        s;
    logic [31:0] ins, pc, ext;
    logic        dv, hold, exv, fl;
    int          sel;

    do_reset();

    // call then return
    drive(1, mk(JAL, 5'd1, 5'd0), 32'h100, 0, 0, 0, s);
    chk("t1 wen", bus.ret_stack_wen, 1);
    tick();
    drive(1, mk(JALR, 5'd0, 5'd1), 32'h200, 0, 0, 0, s);
    chk("t1 ren", bus.ret_stack_ren, 1);
    chk("t1 pred_valid", bus.pred_valid, 1);
    chk("t1 pred_target", bus.pred_target, 32'h104);
    tick();
    step(0, 0, 0, 1, 32'h104, 0);
    drive(0, 0, 0, 0, 0, 0, s);
    chk("t1 no mispred", bus.mispred, 0);
    chk("t1 cnt", bus.mispred_cnt, 0);
    tick();

    // return on empty stack
    drive(1, mk(JALR, 5'd0, 5'd5), 32'h140, 0, 0, 0, s);
    chk("t2 pred_valid", bus.pred_valid, 0);
    chk("t2 ren", bus.ret_stack_ren, 0);
    tick();
    step(0, 0, 0, 1, 32'h200, 0);
    drive(0, 0, 0, 0, 0, 0, s);
    chk("t2 mispred", bus.mispred, 1);
    chk("t2 mispred_target", bus.mispred_target, 32'h200);
    chk("t2 cnt", bus.mispred_cnt, 1);
    tick();

    // coroutine
    step(1, mk(JAL, 5'd1, 5'd0), 32'h17c, 0, 0, 0);
    drive(1, mk(JALR, 5'd5, 5'd1), 32'h300, 0, 0, 0, s);
    chk("t3 c1 ren", bus.ret_stack_ren, 1);
    chk("t3 c1 pred_target", bus.pred_target, 32'h180);
    chk("t3 c1 stall", bus.dec_stall, 1);
    chk("t3 c1 wen", bus.ret_stack_wen, 0);
    tick();
    drive(1, mk(JALR, 5'd5, 5'd1), 32'h300, 0, 0, 0, s);
    chk("t3 c2 wen", bus.ret_stack_wen, 1);
    chk("t3 c2 ren", bus.ret_stack_ren, 0);
    chk("t3 c2 stall", bus.dec_stall, 0);
    tick();
    step(0, 0, 0, 1, 32'h180, 0);

    // fill the pending FIFO
    for (int i = 0; i < 5; i++) step(1, mk(JAL, 5'd1, 5'd0), 32'h1000 + 32'(i * 16), 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, mk(JALR, 5'd0, 5'd1), 32'h2000 + 32'(i * 4), 0, 0, 0, s);
      chk("t4 no stall", bus.dec_stall, 0);
      tick();
    end
    drive(1, mk(JALR, 5'd0, 5'd1), 32'h2010, 0, 0, 0, s);
    chk("t4 stall fifth", bus.dec_stall, 1);
    chk("t4 ren held", bus.ret_stack_ren, 0);
    tick();
    ext = pend[0].tgt;
    drive(1, mk(JALR, 5'd0, 5'd1), 32'h2010, 1, ext, 0, s);
    chk("t4 stall while resolving", bus.dec_stall, 1);
    tick();
    drive(1, mk(JALR, 5'd0, 5'd1), 32'h2010, 0, 0, 0, s);
    chk("t4 released", bus.dec_stall, 0);
    chk("t4 ren after release", bus.ret_stack_ren, 1);
    tick();
    step(0, 0, 0, 0, 0, 1);

    // mispredict clears younger entries
    do_reset();
    for (int i = 0; i < 3; i++) step(1, mk(JAL, 5'd5, 5'd0), 32'h400 + 32'(i * 8), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, mk(JALR, 5'd0, 5'd5), 32'h500, 0, 0, 0);
    step(0, 0, 0, 1, 32'hdead0, 0);
    drive(0, 0, 0, 1, 32'h40c, 0, s);
    chk("t5 first mispred", bus.mispred, 1);
    chk("t5 cnt1", bus.mispred_cnt, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, s);
    chk("t5 second mispred", bus.mispred, 1);
    chk("t5 cnt2", bus.mispred_cnt, 2);
    chk("t5 target", bus.mispred_target, 32'h40c);
    tick();

    // flush against resolve and pop
    step(1, mk(JAL, 5'd1, 5'd0), 32'h600, 0, 0, 0);
    step(1, mk(JAL, 5'd1, 5'd0), 32'h610, 0, 0, 0);
    step(1, mk(JALR, 5'd0, 5'd1), 32'h700, 0, 0, 0);
    drive(1, mk(JALR, 5'd0, 5'd1), 32'h704, 1, 32'hbad0, 1, s);
    chk("t6 ren", bus.ret_stack_ren, 0);
    chk("t6 pred_valid", bus.pred_valid, 0);
    tick();
    drive(0, 0, 0, 1, 32'h604, 0, s);
    chk("t6 no mispred", bus.mispred, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, s);
    chk("t6 empty fifo mispred", bus.mispred, 1);
    tick();

    // reset during CORO drops the push
    step(1, mk(JAL, 5'd1, 5'd0), 32'h800, 0, 0, 0);
    step(1, mk(JAL, 5'd1, 5'd0), 32'h810, 0, 0, 0);
    step(1, mk(JALR, 5'd1, 5'd5), 32'h900, 0, 0, 0);
    do_reset();
    drive(1, mk(JALR, 5'd0, 5'd1), 32'h904, 0, 0, 0, s);
    chk("t7 idle ren", bus.ret_stack_ren, 1);
    chk("t7 idle wen", bus.ret_stack_wen, 0);
    chk("t7 idle target", bus.pred_target, 32'h804);
    tick();

    // random traffic
    hold = 0;
    ins  = 0;
    pc   = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        sel = $urandom_range(0, 9);
        ins = {12'($urandom()), pick_reg(), 3'b000, pick_reg(),
               (sel < 3) ? JAL : (sel < 9) ? JALR : 7'b0010011};
        pc  = {16'h0, 14'($urandom()), 2'b00};
        dv  = ($urandom_range(0, 9) < 8);
      end else dv = 1;
      exv = ($urandom_range(0, 3) == 0);
      ext = (pend.size() != 0 && $urandom_range(0, 3) != 0) ? pend[0].tgt : $urandom();
      fl  = ($urandom_range(0, 29) == 0);
      drive(dv, ins, pc, exv, ext, fl, s);
      hold = s;
      tick();
    end

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("comb_q drained", comb_q.size(), 0);
    chk("mis_q drained", mis_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
